// File: rtl/mem_access_ctrl_if.sv
// Memory-side request/acknowledge bus between the access controller and data memory.
interface mem_access_ctrl_if #(
  parameter int AW = 6
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  // Controller side: issues requests, receives completion and read data.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // Memory side: accepts requests, returns completion and read data.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: decodes the byte address,
// issues one request per load/store, stalls the pipeline until the memory
// acknowledges (or the wait times out) and returns the loaded word.
module mem_access_ctrl #(
  parameter int BASE_ADDR = 1024,
  parameter int AW        = 6,
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            alu_res,
  input  logic [31:0]            rm_val,
  output logic                   freeze,
  output logic [31:0]            data_mem,
  output logic                   err_range,
  output logic                   err_timeout,
  mem_access_ctrl_if.master      mem_if
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;
  localparam int          CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] BASE   = 32'(BASE_ADDR);
  // Abort fires on the last permitted WAIT cycle, so the counter stops one short.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_data_mem;
  logic          r_err_range;
  logic          r_err_timeout;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_active;

  // Address decode: word index relative to the data-memory base; byte offset dropped.
  always_comb begin
    w_off      = alu_res - BASE;
    w_idx      = AW'(w_off >> 2);
    w_in_range = (alu_res >= BASE) && ((w_off >> (AW + 2)) == 32'd0);
    w_active   = MEM_R_EN | MEM_W_EN;
  end

  // Stall while a request is being launched or outstanding; DONE releases the pipe.
  always_comb begin
    freeze = 1'b0;
    if (r_state == S_WAIT)
      freeze = 1'b1;
    else if (r_state == S_IDLE)
      freeze = w_active & w_in_range;
  end

  // Access FSM with registered memory request, load result and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_data_mem    <= '0;
      r_err_range   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_range <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_active) begin
            r_data_mem <= '0;
            if (w_in_range) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= MEM_W_EN;
              r_mem_addr  <= w_idx;
              r_mem_wdata <= rm_val;
              r_cnt       <= '0;
              r_state     <= S_WAIT;
            end else begin
              r_err_range <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem_if.mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we)
              r_data_mem <= mem_if.mem_rdata;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req     <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Pipeline still shows the same instruction here, so requests are ignored.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_if.mem_req   = r_mem_req;
  assign mem_if.mem_we    = r_mem_we;
  assign mem_if.mem_addr  = r_mem_addr;
  assign mem_if.mem_wdata = r_mem_wdata;
  assign data_mem         = r_data_mem;
  assign err_range        = r_err_range;
  assign err_timeout      = r_err_timeout;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares on each completed access or range error.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] alu_res, rm_val;
  logic        freeze;
  logic [31:0] data_mem;
  logic        err_range, err_timeout;

  mem_access_ctrl_if #(.AW(6)) mif ();

  mem_access_ctrl #(.BASE_ADDR(1024), .AW(6), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .alu_res    (alu_res),
    .rm_val     (rm_val),
    .freeze     (freeze),
    .data_mem   (data_mem),
    .err_range  (err_range),
    .err_timeout(err_timeout),
    .mem_if     (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] dmem;
    int          frz;
    int          reqc;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts freeze/request cycles and checks each completion.
  initial begin
    int          fc, rc;
    logic        unst;
    logic        l_we;
    logic [5:0]  l_addr;
    logic [31:0] l_wdata;
    exp_t        e;
    fc = 0; rc = 0; unst = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        fc = 0; rc = 0; unst = 1'b0;
      end else begin
        if (freeze) fc++;
        if (mif.mem_req) begin
          if (rc == 0) begin
            l_we = mif.mem_we; l_addr = mif.mem_addr; l_wdata = mif.mem_wdata;
          end else if (l_we !== mif.mem_we || l_addr !== mif.mem_addr || l_wdata !== mif.mem_wdata) begin
            unst = 1'b1;
          end
          rc++;
        end
        if (!freeze && fc > 0) begin
          if (q.size() == 0) begin
            chk("unexpected_completion", 32'(fc), 32'd0);
          end else begin
            e = q.pop_front();
            chk("kind_access", {31'd0, e.is_err}, 32'd0);
            chk("mem_we", {31'd0, l_we}, {31'd0, e.we});
            chk("mem_addr", {26'd0, l_addr}, {26'd0, e.addr});
            chk("mem_wdata", l_wdata, e.wdata);
            chk("req_stable", {31'd0, unst}, 32'd0);
            chk("data_mem_done", data_mem, e.dmem);
            chk("freeze_cycles", 32'(fc), 32'(e.frz));
            chk("req_cycles", 32'(rc), 32'(e.reqc));
            chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.tmo});
            chk("req_dropped", {31'd0, mif.mem_req}, 32'd0);
          end
          fc = 0; rc = 0; unst = 1'b0;
        end
        if (err_range) begin
          if (q.size() == 0) begin
            chk("unexpected_err_range", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("kind_err", {31'd0, e.is_err}, 32'd1);
            chk("err_no_req", {31'd0, mif.mem_req}, 32'd0);
            chk("err_no_freeze", {31'd0, freeze}, 32'd0);
            chk("err_data_mem", data_mem, 32'd0);
          end
        end
      end
    end
  end

  // Launch one access and answer it; returns in the DONE cycle.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_after,
                           input logic [31:0] rd, input logic hold, input exp_t e);
    q.push_back(e);
    @(posedge clk); #1;
    MEM_R_EN = r; MEM_W_EN = w; alu_res = a; rm_val = wd;
    @(posedge clk); #1;
    if (!hold) begin MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; end
    if (ack_after > 0) begin
      repeat (ack_after - 1) begin @(posedge clk); #1; end
      mif.mem_ack = 1'b1; mif.mem_rdata = rd;
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
    end else begin
      repeat (15) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_err(input logic [31:0] a);
    exp_t e;
    e = '{is_err: 1'b1, we: 1'b0, addr: 6'd0, wdata: 32'd0, dmem: 32'd0, frz: 0, reqc: 0, tmo: 1'b0};
    q.push_back(e);
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; alu_res = a;
    #1 chk("oor_freeze_low", {31'd0, freeze}, 32'd0);
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic exp_t mk(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                              input logic [31:0] dm, input int frz, input int reqc, input logic tmo);
    exp_t e;
    e = '{is_err: 1'b0, we: we, addr: addr, wdata: wd, dmem: dm, frz: frz, reqc: reqc, tmo: tmo};
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; alu_res = '0; rm_val = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    #2;
    chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
    chk("rst_mem_addr", {26'd0, mif.mem_addr}, 32'd0);
    chk("rst_data_mem", data_mem, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_errs", {30'd0, err_range, err_timeout}, 32'd0);
    @(posedge clk); #3 rst = 1'b1;

    // Read at 1032, ack in first WAIT cycle.
    do_access(1, 0, 32'd1032, 32'd0, 1, 32'h12345678, 0, mk(0, 6'd2, 32'd0, 32'h12345678, 2, 1, 0));
    // Read+write collapses to write; read data on ack must not reach data_mem.
    do_access(1, 1, 32'd1024, 32'hA5A5A5A5, 3, 32'hDEADBEEF, 0, mk(1, 6'd0, 32'hA5A5A5A5, 32'd0, 4, 3, 0));
    // Misaligned byte address inside word 19.
    do_access(1, 0, 32'd1103, 32'd0, 2, 32'hCAFEF00D, 0, mk(0, 6'd19, 32'd0, 32'hCAFEF00D, 3, 2, 0));
    // Out-of-range below base and just past the top word.
    do_err(32'd1020);
    do_err(32'd1280);
    // Load held through DONE, then a new load: one request each.
    do_access(1, 0, 32'd1040, 32'd0, 1, 32'h11112222, 1, mk(0, 6'd4, 32'd0, 32'h11112222, 2, 1, 0));
    do_access(1, 0, 32'd1044, 32'd0, 1, 32'h33334444, 0, mk(0, 6'd5, 32'd0, 32'h33334444, 2, 1, 0));
    // Timeout: no ack; ack in DONE is ignored; flag is sticky.
    do_access(1, 0, 32'd1028, 32'd0, 0, 32'd0, 0, mk(0, 6'd1, 32'd0, 32'd0, 16, 15, 1));
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("done_ack_ignored", data_mem, 32'd0);
    chk("tmo_sticky", {31'd0, err_timeout}, 32'd1);
    chk("idle_no_req", {31'd0, mif.mem_req}, 32'd0);

    // Async reset in the middle of a WAIT on the top word.
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; alu_res = 32'd1276; rm_val = 32'h0;
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    chk("top_word_addr", {26'd0, mif.mem_addr}, 32'd63);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, mif.mem_req}, 32'd0);
    chk("arst_mem_addr", {26'd0, mif.mem_addr}, 32'd0);
    chk("arst_we_wdata", {31'd0, mif.mem_we} | mif.mem_wdata, 32'd0);
    chk("arst_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("arst_freeze", {31'd0, freeze}, 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BADBAD0;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    chk("late_ack_data", data_mem, 32'd0);
    chk("late_ack_req", {31'd0, mif.mem_req}, 32'd0);
    chk("late_ack_freeze", {31'd0, freeze}, 32'd0);

    // Normal operation after reset.
    do_access(1, 0, 32'd1036, 32'd0, 1, 32'h0F0F0F0F, 0, mk(0, 6'd3, 32'd0, 32'h0F0F0F0F, 2, 1, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
